cr_huf_comp_sa_st_rd: RTL and testbench

Downstream consumer of the symbol-table (ST) stage in the Huffman compressor. Once the ST stage reports a ready table, this block sequentially reads every code/length entry from the ST LUT and streams the entries to the symbol-assign datapath through a small credit-protected FIFO. It then pulses sa_st_read_done, which returns the ST stage to idle. In pass-through frames there is no table, so the block issues the done pulse without any reads.

---
 rtl/cr_huf_comp_sa_st_rd_pkg.sv | 28 ++
 rtl/cr_huf_comp_sa_st_rd_fifo.sv | 67 ++++++
 rtl/cr_huf_comp_sa_st_rd.sv | 176 +++++++++++++++++
 tb/tb_cr_huf_comp_sa_st_rd.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_huf_comp_sa_st_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cr_huf_comp_sa_st_rd_pkg
// Description : Shared types and constants for the Huffman compressor SA/ST read stage.
// Revision    : 1.0 - initial release
// ============================================================================
package cr_huf_comp_sa_st_rd_pkg;

    localparam int HUF_NUM_SYM = 286;
    localparam int HUF_CODE_W  = 27;
    localparam int HUF_LEN_W   = 5;
    localparam int HUF_LUT_AW  = 9;

    typedef enum logic [2:0] {
        SA_IDLE     = 3'd0,
        SA_WAIT_TBL = 3'd1,
        SA_READ     = 3'd2,
        SA_DRAIN    = 3'd3,
        SA_DONE     = 3'd4
    } e_sa_state;

    typedef struct packed {
        logic [HUF_LEN_W-1:0]  len;
        logic [HUF_CODE_W-1:0] code;
    } s_st_lut_entry;

endpackage
`default_nettype wire

// File: rtl/cr_huf_comp_sa_st_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cr_huf_comp_sa_st_fifo
// Description : Small synchronous FIFO with occupancy count, full and empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module cr_huf_comp_sa_st_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 41
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_wdata,
    input  logic                       i_pop,
    output logic [W-1:0]               o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (c_AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];

    // A push at full is accepted when the same cycle frees a slot.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cr_huf_comp_sa_st_rd.sv
`default_nettype none
// ============================================================================
// Module      : cr_huf_comp_sa_st_rd
// Description : Reads every ST LUT entry and streams it to the symbol-assign
//               datapath through a credit-protected FIFO, then pulses done.
//               Optional macro CR_HUF_COMP_SA_SKIP_ZERO_LEN_EN drops len==0 entries.
// Revision    : 1.0 - initial release
// ============================================================================
module cr_huf_comp_sa_st_rd
    import cr_huf_comp_sa_st_rd_pkg::*;
#(
    parameter int NUM_SYM    = HUF_NUM_SYM,
    parameter int LUT_AW     = HUF_LUT_AW,
    parameter int CODE_W     = HUF_CODE_W,
    parameter int LEN_W      = HUF_LEN_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      st_rdy,
    input  logic                      st_tbl_rdy,
    input  logic                      st_pass_thru,
    input  logic [LUT_AW-1:0]         st_sym_cnt,
    output logic                      sa_st_lut_rd,
    output logic [LUT_AW-1:0]         sa_st_lut_addr,
    input  logic [LEN_W+CODE_W-1:0]   st_sa_lut_rdata,
    output logic                      sa_sym_vld,
    input  logic                      sa_sym_rdy,
    output logic [LUT_AW-1:0]         sa_sym_addr,
    output logic [LEN_W-1:0]          sa_sym_len,
    output logic [CODE_W-1:0]         sa_sym_code,
    output logic                      sa_st_read_done
);

    localparam int                c_ENT_W   = LEN_W + CODE_W;
    localparam int                c_FIFO_W  = LUT_AW + c_ENT_W;
    localparam int                c_CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LUT_AW-1:0] c_MAX_CNT = LUT_AW'(NUM_SYM);

    e_sa_state            r_state;
    e_sa_state            w_state_nxt;
    logic [LUT_AW-1:0]    r_cnt;
    logic [LUT_AW-1:0]    r_addr;
    logic [LUT_AW-1:0]    r_tag;
    logic                 r_inflight;
    logic                 r_done;

    logic                 w_exit_idle;
    logic                 w_rd;
    logic                 w_last_addr;
    logic                 w_credit;
    logic [LUT_AW-1:0]    w_cnt_in;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_vld;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    logic [c_CNT_W-1:0]   w_fifo_cnt;
    logic [c_FIFO_W-1:0]  w_fifo_rdata;

    assign w_cnt_in    = (st_sym_cnt > c_MAX_CNT) ? c_MAX_CNT : st_sym_cnt;
    assign w_last_addr = (r_addr == (r_cnt - LUT_AW'(1)));
    // The read whose data returns next cycle still owns a FIFO slot.
    assign w_credit    = ({1'b0, w_fifo_cnt} + {{c_CNT_W{1'b0}}, r_inflight})
                         < (c_CNT_W+1)'(FIFO_DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_exit_idle = 1'b0;
        w_rd        = 1'b0;
        case (r_state)
            SA_IDLE: begin
                if (st_tbl_rdy) begin
                    w_exit_idle = 1'b1;
                    w_state_nxt = SA_READ;
                end else if (st_rdy) begin
                    w_exit_idle = 1'b1;
                    w_state_nxt = st_pass_thru ? SA_DONE : SA_WAIT_TBL;
                end
            end
            SA_WAIT_TBL: begin
                if (st_tbl_rdy) begin
                    w_state_nxt = SA_READ;
                end
            end
            SA_READ: begin
                if (r_cnt == '0) begin
                    w_state_nxt = SA_DRAIN;
                end else if (w_credit) begin
                    w_rd = 1'b1;
                    if (w_last_addr) begin
                        w_state_nxt = SA_DRAIN;
                    end
                end
            end
            SA_DRAIN: begin
                // Leave as the final pop empties the FIFO, so done follows it by one cycle.
                if (!r_inflight &&
                    (w_fifo_empty || ((w_fifo_cnt == c_CNT_W'(1)) && w_pop))) begin
                    w_state_nxt = SA_DONE;
                end
            end
            SA_DONE: begin
                w_state_nxt = SA_IDLE;
            end
            default: begin
                w_state_nxt = SA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SA_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_tag      <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= (r_state == SA_DONE);
            r_inflight <= w_rd;
            if (w_rd) begin
                r_tag <= r_addr;
            end
            if (w_exit_idle) begin
                r_cnt  <= w_cnt_in;
                r_addr <= '0;
            end else if (w_rd && !w_last_addr) begin
                r_addr <= r_addr + LUT_AW'(1);
            end
        end
    end

`ifdef CR_HUF_COMP_SA_SKIP_ZERO_LEN_EN
    assign w_push = r_inflight && (st_sa_lut_rdata[c_ENT_W-1 -: LEN_W] != '0);
`else
    assign w_push = r_inflight;
`endif

    assign w_vld = ~w_fifo_empty;
    assign w_pop = w_vld & sa_sym_rdy;

    cr_huf_comp_sa_st_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (c_FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({r_tag, st_sa_lut_rdata}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_cnt)
    );

    assign sa_st_lut_rd    = w_rd;
    assign sa_st_lut_addr  = r_addr;
    assign sa_sym_vld      = w_vld;
    assign sa_sym_addr     = w_vld ? w_fifo_rdata[c_FIFO_W-1 -: LUT_AW] : '0;
    assign sa_sym_len      = w_vld ? w_fifo_rdata[c_ENT_W-1 -: LEN_W]   : '0;
    assign sa_sym_code     = w_vld ? w_fifo_rdata[CODE_W-1:0]           : '0;
    assign sa_st_read_done = r_done;

`ifndef SYNTHESIS
    a_sym_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        w_exit_idle |-> (st_sym_cnt <= c_MAX_CNT));
    a_fifo_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_fifo_full && !w_pop));
`endif

endmodule
`default_nettype wire

// File: tb/tb_cr_huf_comp_sa_st_rd.sv
`default_nettype none
// ============================================================================
// Module      : tb_cr_huf_comp_sa_st_rd
// Description : Directed self-checking bench for cr_huf_comp_sa_st_rd.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cr_huf_comp_sa_st_rd;
    import cr_huf_comp_sa_st_rd_pkg::*;

    localparam int AW = 9;
    localparam int LW = 5;
    localparam int CW = 27;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          st_rdy = 1'b0;
    logic          st_tbl_rdy = 1'b0;
    logic          st_pass_thru = 1'b0;
    logic [AW-1:0] st_sym_cnt = '0;
    logic          sa_sym_rdy = 1'b1;
    logic [LW+CW-1:0] lut_rdata = '0;
    logic          sa_st_lut_rd;
    logic [AW-1:0] sa_st_lut_addr;
    logic          sa_sym_vld;
    logic [AW-1:0] sa_sym_addr;
    logic [LW-1:0] sa_sym_len;
    logic [CW-1:0] sa_sym_code;
    logic          sa_st_read_done;

    int vectors = 0;
    int miscompares = 0;
    int lut_mode = 0;

    cr_huf_comp_sa_st_rd dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .st_rdy          (st_rdy),
        .st_tbl_rdy      (st_tbl_rdy),
        .st_pass_thru    (st_pass_thru),
        .st_sym_cnt      (st_sym_cnt),
        .sa_st_lut_rd    (sa_st_lut_rd),
        .sa_st_lut_addr  (sa_st_lut_addr),
        .st_sa_lut_rdata (lut_rdata),
        .sa_sym_vld      (sa_sym_vld),
        .sa_sym_rdy      (sa_sym_rdy),
        .sa_sym_addr     (sa_sym_addr),
        .sa_sym_len      (sa_sym_len),
        .sa_sym_code     (sa_sym_code),
        .sa_st_read_done (sa_st_read_done)
    );

    always #5 clk = ~clk;

    // LUT model: mode 0 gives {len=addr[3:0]+1, code=addr}; mode 1 the sparse-length table.
    function automatic s_st_lut_entry lut_fn(input logic [AW-1:0] a, input int mode);
        s_st_lut_entry e;
        e.code = CW'(a);
        if (mode == 0) begin
            e.len = LW'(a[3:0]) + LW'(1);
        end else begin
            case (a)
                9'd0:    e.len = 5'd3;
                9'd3:    e.len = 5'd4;
                9'd5:    e.len = 5'd5;
                default: e.len = 5'd0;
            endcase
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (sa_st_lut_rd) begin
            lut_rdata <= lut_fn(sa_st_lut_addr, lut_mode);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_rd = 0;
    int n_x = 0;
    int n_done = 0;
    int done_cyc = 0;
    int rd_cyc [256];
    int x_cyc [256];
    logic [AW-1:0] x_addr [256];
    logic [LW-1:0] x_len [256];
    logic [CW-1:0] x_code [256];

    always @(negedge clk) begin
        if (rst_n) begin
            if (sa_st_lut_rd) begin
                rd_cyc[n_rd] = cyc;
                n_rd = n_rd + 1;
            end
            if (sa_sym_vld && sa_sym_rdy) begin
                x_cyc[n_x]  = cyc;
                x_addr[n_x] = sa_sym_addr;
                x_len[n_x]  = sa_sym_len;
                x_code[n_x] = sa_sym_code;
                n_x = n_x + 1;
            end
            if (sa_st_read_done) begin
                done_cyc = cyc;
                n_done = n_done + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int base, input int budget);
        int k = 0;
        while (n_done == base && k < budget) begin
            step(1);
            k++;
        end
        step(2);
    endtask

    task automatic chk_entry(input int idx, input logic [AW-1:0] ea,
                             input logic [LW-1:0] el, input logic [CW-1:0] ec);
        chk($sformatf("addr[%0d]", idx), 64'(x_addr[idx]), 64'(ea));
        chk($sformatf("len[%0d]", idx),  64'(x_len[idx]),  64'(el));
        chk($sformatf("code[%0d]", idx), 64'(x_code[idx]), 64'(ec));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_rd, b_x, b_done, t0, k;
        logic [AW-1:0] e_addr [6];
        logic [LW-1:0] e_len [6];
        int n_exp;

        // Reset state
        step(3);
        chk("rst_lut_rd",   64'(sa_st_lut_rd),    64'd0);
        chk("rst_lut_addr", 64'(sa_st_lut_addr),  64'd0);
        chk("rst_vld",      64'(sa_sym_vld),      64'd0);
        chk("rst_done",     64'(sa_st_read_done), 64'd0);
        rst_n = 1'b1;
        step(2);

        // 1. Pass-through: done is registered one cycle after the DONE state
        b_rd = n_rd; b_done = n_done;
        st_rdy = 1'b1; st_pass_thru = 1'b1; t0 = cyc;
        step(1);
        st_rdy = 1'b0; st_pass_thru = 1'b0;
        step(5);
        chk("pt_done_cnt", 64'(n_done - b_done), 64'd1);
        chk("pt_done_lat", 64'(done_cyc - t0),   64'd2);
        chk("pt_reads",    64'(n_rd - b_rd),     64'd0);

        // 2. Normal table, cnt=8, table ready 5 cycles after st_rdy
        b_rd = n_rd; b_x = n_x; b_done = n_done;
        st_sym_cnt = 9'd8; st_rdy = 1'b1;
        step(1);
        st_rdy = 1'b0;
        step(4);
        st_tbl_rdy = 1'b1;
        step(1);
        st_tbl_rdy = 1'b0;
        wait_done(b_done, 100);
        chk("nt_reads",    64'(n_rd - b_rd),   64'd8);
        chk("nt_entries",  64'(n_x - b_x),     64'd8);
        chk("nt_done_cnt", 64'(n_done - b_done), 64'd1);
        chk("nt_first_lat", 64'(x_cyc[b_x] - rd_cyc[b_rd]), 64'd2);
        chk("nt_b2b",      64'(x_cyc[b_x+7] - x_cyc[b_x]), 64'd7);
        chk("nt_done_lat", 64'(done_cyc - x_cyc[b_x+7]),   64'd2);
        for (int i = 0; i < 8; i++) begin
            chk_entry(b_x + i, AW'(i), LW'(i + 1), CW'(i));
        end

        // 3. Backpressure: cnt=10, downstream stalled 20 cycles
        b_rd = n_rd; b_x = n_x; b_done = n_done;
        sa_sym_rdy = 1'b0; st_sym_cnt = 9'd10; st_tbl_rdy = 1'b1;
        step(1);
        st_tbl_rdy = 1'b0;
        step(20);
        chk("bp_reads_held", 64'(n_rd - b_rd), 64'd4);
        chk("bp_no_xfer",    64'(n_x - b_x),   64'd0);
        chk("bp_vld_held",   64'(sa_sym_vld),  64'd1);
        chk("bp_addr_held",  64'(sa_sym_addr), 64'd0);
        chk("bp_len_held",   64'(sa_sym_len),  64'd1);
        sa_sym_rdy = 1'b1;
        wait_done(b_done, 200);
        chk("bp_reads",    64'(n_rd - b_rd),     64'd10);
        chk("bp_entries",  64'(n_x - b_x),       64'd10);
        chk("bp_done_cnt", 64'(n_done - b_done), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk_entry(b_x + i, AW'(i), LW'(i + 1), CW'(i));
        end

        // 4. Empty table: exit at edge t0+1, done 3 cycles later
        b_rd = n_rd; b_done = n_done;
        st_sym_cnt = 9'd0; st_tbl_rdy = 1'b1; t0 = cyc;
        step(1);
        st_tbl_rdy = 1'b0;
        wait_done(b_done, 20);
        chk("et_done_cnt", 64'(n_done - b_done), 64'd1);
        chk("et_done_lat", 64'(done_cyc - (t0 + 1)), 64'd3);
        chk("et_reads",    64'(n_rd - b_rd), 64'd0);

        // 5. Reset mid-read after 3 entries, then a clean cnt=2 frame
        b_x = n_x; b_done = n_done;
        st_sym_cnt = 9'd8; st_rdy = 1'b1;
        step(1);
        st_rdy = 1'b0;
        step(1);
        st_tbl_rdy = 1'b1;
        step(1);
        st_tbl_rdy = 1'b0;
        k = 0;
        while ((n_x - b_x) < 3 && k < 50) begin
            step(1);
            k++;
        end
        chk("mr_three_out", 64'((n_x - b_x) >= 3), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_lut_rd",   64'(sa_st_lut_rd),    64'd0);
        chk("mr_lut_addr", 64'(sa_st_lut_addr),  64'd0);
        chk("mr_vld",      64'(sa_sym_vld),      64'd0);
        chk("mr_addr",     64'(sa_sym_addr),     64'd0);
        chk("mr_len",      64'(sa_sym_len),      64'd0);
        chk("mr_code",     64'(sa_sym_code),     64'd0);
        chk("mr_done",     64'(sa_st_read_done), 64'd0);
        step(2);
        rst_n = 1'b1;
        step(10);
        chk("mr_no_done", 64'(n_done - b_done), 64'd0);
        b_rd = n_rd; b_x = n_x;
        st_sym_cnt = 9'd2; st_tbl_rdy = 1'b1;
        step(1);
        st_tbl_rdy = 1'b0;
        wait_done(b_done, 50);
        chk("mr2_entries",  64'(n_x - b_x),       64'd2);
        chk("mr2_done_cnt", 64'(n_done - b_done), 64'd1);
        for (int i = 0; i < 2; i++) begin
            chk_entry(b_x + i, AW'(i), LW'(i + 1), CW'(i));
        end

        // 6. Lengths {3,0,0,4,0,5}
        b_rd = n_rd; b_x = n_x; b_done = n_done;
        lut_mode = 1;
`ifdef CR_HUF_COMP_SA_SKIP_ZERO_LEN_EN
        n_exp = 3;
        e_addr[0] = 9'd0; e_len[0] = 5'd3;
        e_addr[1] = 9'd3; e_len[1] = 5'd4;
        e_addr[2] = 9'd5; e_len[2] = 5'd5;
`else
        n_exp = 6;
        e_addr[0] = 9'd0; e_len[0] = 5'd3;
        e_addr[1] = 9'd1; e_len[1] = 5'd0;
        e_addr[2] = 9'd2; e_len[2] = 5'd0;
        e_addr[3] = 9'd3; e_len[3] = 5'd4;
        e_addr[4] = 9'd4; e_len[4] = 5'd0;
        e_addr[5] = 9'd5; e_len[5] = 5'd5;
`endif
        st_sym_cnt = 9'd6; st_tbl_rdy = 1'b1;
        step(1);
        st_tbl_rdy = 1'b0;
        wait_done(b_done, 50);
        chk("zl_reads",    64'(n_rd - b_rd),     64'd6);
        chk("zl_entries",  64'(n_x - b_x),       64'(n_exp));
        chk("zl_done_cnt", 64'(n_done - b_done), 64'd1);
        for (int i = 0; i < n_exp; i++) begin
            chk_entry(b_x + i, e_addr[i], e_len[i], CW'(e_addr[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
